// File: rtl/shift_unit_arbiter_if.sv
// Handshake bundle between two shift requesters, the shared shifter and the result consumer.
// master is the arbiter's view; slave is the environment's view.
interface shift_unit_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic [SHW-1:0]   req0_shamt;
  logic [1:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic [SHW-1:0]   req1_shamt;
  logic [1:0]       req1_op;

  logic [WIDTH-1:0] sh_in;
  logic [SHW-1:0]   sh_shamt;
  logic [1:0]       sh_op;
  logic [WIDTH-1:0] sh_out;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic             rsp_err;

  modport master (
    input  req0_valid, req0_data, req0_shamt, req0_op,
    output req0_ready,
    input  req1_valid, req1_data, req1_shamt, req1_op,
    output req1_ready,
    output sh_in, sh_shamt, sh_op,
    input  sh_out,
    output rsp_valid, rsp_data, rsp_id, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output req0_valid, req0_data, req0_shamt, req0_op,
    input  req0_ready,
    output req1_valid, req1_data, req1_shamt, req1_op,
    input  req1_ready,
    input  sh_in, sh_shamt, sh_op,
    output sh_out,
    input  rsp_valid, rsp_data, rsp_id, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one external barrel shifter between the ALU issue path (0)
// and the multdiv sequencer (1), with a one-entry tagged result register.
module shift_unit_arbiter_lane #(
  parameter int SHW = 5
) (
  input  logic [SHW-1:0] shamt,
  input  logic [1:0]     op,
  output logic [SHW-1:0] eff_shamt,
  output logic [1:0]     eff_op,
  output logic           err
);
  // Illegal op becomes a zero-distance sll so the operand passes through untouched.
  assign err       = (op == 2'b11);
  assign eff_op    = err ? 2'b00 : op;
  assign eff_shamt = err ? '0 : shamt;
endmodule

module shift_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input logic                  clock,
  input logic                  reset,
  shift_unit_arbiter_if.master bus
);
  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   shamt;
    logic [1:0]       op;
  } req_t;

  logic [NUM_REQ-1:0]          req_valid;
  req_t [NUM_REQ-1:0]          req;
  logic [NUM_REQ-1:0][SHW-1:0] eff_shamt;
  logic [NUM_REQ-1:0][1:0]     eff_op;
  logic [NUM_REQ-1:0]          req_err;

  logic gnt_vld;
  logic gnt_id;
  logic last_grant;
  logic out_free;
  logic accept;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign req[0]    = {bus.req0_data, bus.req0_shamt, bus.req0_op};
  assign req[1]    = {bus.req1_data, bus.req1_shamt, bus.req1_op};

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    shift_unit_arbiter_lane #(.SHW(SHW)) u_lane (
      .shamt     (req[i].shamt),
      .op        (req[i].op),
      .eff_shamt (eff_shamt[i]),
      .eff_op    (eff_op[i]),
      .err       (req_err[i])
    );
  end

  // With no grant gnt_id stays 0, so the shifter sees requester 0's payload.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    case (req_valid)
      2'b01: begin gnt_vld = 1'b1; gnt_id = 1'b0;        end
      2'b10: begin gnt_vld = 1'b1; gnt_id = 1'b1;        end
      2'b11: begin gnt_vld = 1'b1; gnt_id = ~last_grant; end
      default: ;
    endcase
  end

  assign out_free = ~bus.rsp_valid | bus.rsp_ready;
  assign accept   = gnt_vld & out_free;

  assign bus.req0_ready = accept & ~gnt_id;
  assign bus.req1_ready = accept &  gnt_id;

  assign bus.sh_in    = req[gnt_id].data;
  assign bus.sh_shamt = eff_shamt[gnt_id];
  assign bus.sh_op    = eff_op[gnt_id];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_err   <= 1'b0;
      last_grant    <= 1'b1;
    end else if (accept) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_data  <= bus.sh_out;
      bus.rsp_id    <= gnt_id;
      bus.rsp_err   <= req_err[gnt_id];
      last_grant    <= gnt_id;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Scoreboard bench for shift_unit_arbiter: expected results are queued when a request is
// expected to be accepted and compared when the result register presents them.
module tb_shift_unit_arbiter;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] data;
    logic             err;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  shift_unit_arbiter_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

  shift_unit_arbiter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Shared shifter; op 11 yields a corrupted value so an unsanitised op shows up in the data.
  always_comb begin
    case (bus.sh_op)
      2'b00:   bus.sh_out = bus.sh_in << bus.sh_shamt;
      2'b01:   bus.sh_out = bus.sh_in >> bus.sh_shamt;
      2'b10:   bus.sh_out = $signed(bus.sh_in) >>> bus.sh_shamt;
      default: bus.sh_out = ~bus.sh_in;
    endcase
  end

  function automatic exp_t model(input logic id, input logic [WIDTH-1:0] d,
                                 input logic [SHW-1:0] s, input logic [1:0] op);
    exp_t e;
    e.id  = id;
    e.err = (op == 2'b11);
    case (op)
      2'b00:   e.data = d << s;
      2'b01:   e.data = d >> s;
      2'b10:   e.data = $signed(d) >>> s;
      default: e.data = d;
    endcase
    return e;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [WIDTH-1:0] d, input logic [SHW-1:0] s,
                        input logic [1:0] op);
    bus.req0_valid = v; bus.req0_data = d; bus.req0_shamt = s; bus.req0_op = op;
  endtask

  task automatic drive1(input logic v, input logic [WIDTH-1:0] d, input logic [SHW-1:0] s,
                        input logic [1:0] op);
    bus.req1_valid = v; bus.req1_data = d; bus.req1_shamt = s; bus.req1_op = op;
  endtask

  task automatic test_reset;
    @(negedge clock);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data} !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b id=%b err=%b data=%h want all zero",
               bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data);
    end
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle_ready got %b%b want 00", bus.req1_ready, bus.req0_ready);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single;
    exp_t e;
    drive0(1'b1, 32'h0000_0001, 5'd4, 2'b00);
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL single_ready got %b%b want 01", bus.req1_ready, bus.req0_ready);
    end
    exp_q.push_back(model(1'b0, 32'h0000_0001, 5'd4, 2'b00));
    tick();
    drive0(1'b0, '0, '0, 2'b00);
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {1'b1, e.id, e.data, e.err}) begin
      errors++;
      $display("FAIL single_rsp got v=%b id=%b data=%h err=%b want v=1 id=%b data=%h err=%b",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, e.id, e.data, e.err);
    end
    tick();
    @(negedge clock);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain got rsp_valid=%b want 0", bus.rsp_valid);
    end
    tick();
  endtask

  task automatic test_round_robin;
    exp_t e;
    logic id;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drive0(1'b1, 32'h8000_0000, 5'd31, 2'b10);
    drive1(1'b1, 32'h8000_0000, 5'd31, 2'b01);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      id = 1'(i % 2);
      @(negedge clock);
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== {id, ~id}) begin
        errors++;
        $display("FAIL rr_ready[%0d] got %b%b want %b%b", i, bus.req1_ready, bus.req0_ready, id, ~id);
      end
      if (i > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {1'b1, e.id, e.data, e.err}) begin
          errors++;
          $display("FAIL rr_rsp[%0d] got v=%b id=%b data=%h err=%b want id=%b data=%h err=%b", i,
                   bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, e.id, e.data, e.err);
        end
      end
      exp_q.push_back(model(id, 32'h8000_0000, 5'd31, id ? 2'b01 : 2'b10));
      tick();
    end
    drive0(1'b0, '0, '0, 2'b00);
    drive1(1'b0, '0, '0, 2'b00);
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {1'b1, e.id, e.data, e.err}) begin
      errors++;
      $display("FAIL rr_rsp_last got v=%b id=%b data=%h err=%b want id=%b data=%h err=%b",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, e.id, e.data, e.err);
    end
    tick();
  endtask

  task automatic test_backpressure;
    exp_t e;
    bus.rsp_ready = 1'b0;
    drive0(1'b1, 32'h0000_000F, 5'd1, 2'b00);
    @(negedge clock);
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_first_ready got %b%b want 01", bus.req1_ready, bus.req0_ready);
    end
    exp_q.push_back(model(1'b0, 32'h0000_000F, 5'd1, 2'b00));
    tick();
    drive0(1'b0, '0, '0, 2'b00);
    drive1(1'b1, 32'h0000_00F0, 5'd4, 2'b01);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      e = exp_q[0];
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {1'b1, e.id, e.data, e.err}) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b id=%b data=%h err=%b want id=%b data=%h err=%b", k,
                 bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, e.id, e.data, e.err);
      end
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
        errors++;
        $display("FAIL bp_stall_ready[%0d] got %b%b want 00", k, bus.req1_ready, bus.req0_ready);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release_ready got %b%b want 10", bus.req1_ready, bus.req0_ready);
    end
    e = exp_q.pop_front();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {1'b1, e.id, e.data, e.err}) begin
      errors++;
      $display("FAIL bp_release_rsp got v=%b id=%b data=%h want id=%b data=%h",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, e.id, e.data);
    end
    exp_q.push_back(model(1'b1, 32'h0000_00F0, 5'd4, 2'b01));
    tick();
    drive1(1'b0, '0, '0, 2'b00);
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {1'b1, e.id, e.data, e.err}) begin
      errors++;
      $display("FAIL bp_next_rsp got v=%b id=%b data=%h err=%b want id=%b data=%h err=%b",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, e.id, e.data, e.err);
    end
    tick();
  endtask

  task automatic test_illegal;
    exp_t e;
    bus.rsp_ready = 1'b1;
    drive1(1'b1, 32'h1234_5678, 5'd7, 2'b11);
    @(negedge clock);
    checks++;
    if ({bus.req1_ready, bus.sh_op, bus.sh_shamt, bus.sh_in} !== {1'b1, 2'b00, 5'd0, 32'h1234_5678}) begin
      errors++;
      $display("FAIL illegal_shifter got rdy=%b op=%b shamt=%0d in=%h want rdy=1 op=00 shamt=0 in=12345678",
               bus.req1_ready, bus.sh_op, bus.sh_shamt, bus.sh_in);
    end
    exp_q.push_back(model(1'b1, 32'h1234_5678, 5'd7, 2'b11));
    tick();
    drive1(1'b0, '0, '0, 2'b00);
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {1'b1, e.id, e.data, e.err}) begin
      errors++;
      $display("FAIL illegal_rsp got v=%b id=%b data=%h err=%b want id=%b data=%h err=%b",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, e.id, e.data, e.err);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bus.rsp_ready = 1'b0;
    drive0(1'b1, 32'h0000_00A5, 5'd2, 2'b00);
    tick();
    drive1(1'b1, 32'h0000_005A, 5'd1, 2'b01);
    @(negedge clock);
    checks++;
    if ({bus.rsp_valid, bus.req1_ready, bus.req0_ready} !== 3'b100) begin
      errors++;
      $display("FAIL rmid_pre got v=%b rdy=%b%b want v=1 rdy=00",
               bus.rsp_valid, bus.req1_ready, bus.req0_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data} !== '0) begin
      errors++;
      $display("FAIL rmid_async got v=%b id=%b err=%b data=%h want all zero",
               bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data);
    end
    exp_q.delete();
    tick();
    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rmid_first_grant got %b%b want 01", bus.req1_ready, bus.req0_ready);
    end
    exp_q.push_back(model(1'b0, 32'h0000_00A5, 5'd2, 2'b00));
    tick();
    drive0(1'b0, '0, '0, 2'b00);
    drive1(1'b0, '0, '0, 2'b00);
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {1'b1, e.id, e.data, e.err}) begin
      errors++;
      $display("FAIL rmid_rsp got v=%b id=%b data=%h want id=%b data=%h",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, e.id, e.data);
    end
    tick();
  endtask

  task automatic test_back_to_back_shamt_zero;
    exp_t e;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive0(1'b1, 32'hDEAD_BEEF, 5'd0, 2'(i));
      @(negedge clock);
      checks++;
      if (bus.req0_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d] got %b want 1", i, bus.req0_ready);
      end
      if (i > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {1'b1, e.id, e.data, e.err}) begin
          errors++;
          $display("FAIL b2b_rsp[%0d] got v=%b id=%b data=%h err=%b want id=%b data=%h err=%b", i,
                   bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, e.id, e.data, e.err);
        end
      end
      exp_q.push_back(model(1'b0, 32'hDEAD_BEEF, 5'd0, 2'(i)));
      tick();
    end
    drive0(1'b0, '0, '0, 2'b00);
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {1'b1, e.id, e.data, e.err}) begin
      errors++;
      $display("FAIL b2b_rsp_last got v=%b id=%b data=%h err=%b want id=%b data=%h err=%b",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, e.id, e.data, e.err);
    end
    tick();
  endtask

  initial begin
    drive0(1'b0, '0, '0, 2'b00);
    drive1(1'b0, '0, '0, 2'b00);
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_back_to_back_shamt_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_unit_arbiter.md
Name: shift_unit_arbiter

Overview:
- Shares one combinational barrel-shift datapath between two requesters: requester 0 is the ALU issue path, requester 1 is the multdiv sequencer.
- The shared datapath performs logical left, logical right and arithmetic right shifts.
- Grants round-robin and drives the shared shifter's operand and amount inputs.
- Captures the shifter result in a one-entry output register with a valid/ready handshake and a requester tag.

Parameters:
- WIDTH, 32, data width of operands and result.
- SHW, 5, shift-amount width (log2 WIDTH).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a shift request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_data  in  WIDTH  requester 0 operand.
- req0_shamt  in  SHW  requester 0 shift amount.
- req0_op  in  2  requester 0 op: 00 sll, 01 srl, 10 sra, 11 illegal.
- req1_valid, req1_ready, req1_data, req1_shamt, req1_op  same as requester 0, for requester 1.
- sh_in  out  WIDTH  operand to shared shifter.
- sh_shamt  out  SHW  amount to shared shifter.
- sh_op  out  2  op select to shared shifter.
- sh_out  in  WIDTH  combinational result from shared shifter.
- rsp_valid  out  1  result register holds a result.
- rsp_ready  in  1  consumer takes result this cycle.
- rsp_data  out  WIDTH  registered result.
- rsp_id  out  1  requester that owns rsp_data.
- rsp_err  out  1  result came from an illegal op.

Behaviour:
- Reset:
  - reset low asynchronously clears rsp_valid, rsp_data, rsp_id, rsp_err to 0 and last_grant to 1, so requester 0 wins first.
  - Reset asserted mid-operation drops any held result; no partial state survives.
- out_free = !rsp_valid || rsp_ready. A new request may be accepted in the same cycle the held result drains.
- Grant selection (combinational):
  - Only one valid: grant that requester.
  - Both valid: grant the requester != last_grant.
  - Neither valid: no grant.
- reqN_ready = out_free && grant==N. At most one ready is high per cycle. Ready may depend on valid; requesters must not make valid depend on ready.
- sh_in, sh_shamt and sh_op mux the granted requester's payload. When there is no grant they drive requester 0's payload and the result is not captured.
- Accept = reqN_valid && reqN_ready. On the accepting edge:
  - rsp_data <= sh_out; rsp_id <= N; rsp_valid <= 1; last_grant <= N.
  - rsp_err <= (op==11).
- Illegal op 11: sh_op is forced to 00 and sh_shamt to 0, so rsp_data equals the operand unchanged; rsp_err=1.
- Latency: accepted in cycle T, so rsp_valid is high in cycle T+1. Throughput is 1 result/cycle while rsp_ready is held high.
- Backpressure: with rsp_valid=1 and rsp_ready=0, rsp_data, rsp_id and rsp_err hold stable, and both readies are 0.
- Drain without a new accept (rsp_valid && rsp_ready && no grant): rsp_valid <= 0 next cycle.
- last_grant updates only on an accept, never on an idle or stalled cycle.
- Shift amount 0 returns the operand unchanged for every legal op. No width extension: shift results are truncated to WIDTH.

Test Plan:
- Reset, then req0 sll data=0x0000_0001 shamt=4, rsp_ready=1 -> req0_ready same cycle; next cycle rsp_valid=1, rsp_data=0x0000_0010, rsp_id=0, rsp_err=0.
- Both valid continuously for 4 cycles, rsp_ready=1, req0 sra 0x8000_0000 shamt=31, req1 srl 0x8000_0000 shamt=31 -> rsp_id sequence 0,1,0,1; data 0xFFFF_FFFF then 0x0000_0001 alternating.
- Result held with rsp_ready=0 for 3 cycles while req1 valid -> rsp_data stable, req1_ready=0 throughout; rsp_ready=1 -> req1 accepted that same cycle and its result appears next cycle.
- req1 op=11 data=0x1234_5678 shamt=7 -> rsp_data=0x1234_5678, rsp_err=1, rsp_id=1.
- Assert reset low while rsp_valid=1 and both requesters valid -> rsp_valid=0 immediately (no clock edge); after release, the first grant goes to requester 0.
- shamt=0 for sll, srl, sra on 0xDEAD_BEEF -> rsp_data=0xDEAD_BEEF each time, rsp_err=0.
